// File: rtl/dram_axi_pkg.sv
// Shared types for the DRAM AXI link master: link widths, FSM states, request bundle.
package dram_axi_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RESP
    } dram_mst_state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } dram_req_t;

endpackage

// File: rtl/dram_axi_master.sv
// Single-outstanding AXI master for the DRAM link: turns one core request into
// one AW/W/B or AR/R transaction and hands back a completion.
module dram_axi_master #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    // core request port
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    // core completion port
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    // write address / data / response
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready,
    // read address / data
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rvalid,
    output logic              rready
);
    import dram_axi_pkg::*;

    dram_mst_state_e   state_q, state_d;
    dram_req_t         req_q;
    logic              aw_done, w_done;
    logic              rsp_write_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    // Captured request drives the channel payloads, so they stay stable until handshake.
    assign awaddr    = req_q.addr;
    assign araddr    = req_q.addr;
    assign wdata     = req_q.wdata;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and channel handshake outputs; every ready/valid is a pure state decode.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = req_write ? WR_REQ : RD_REQ;
            end
            WR_REQ: begin
                // AW and W retire independently; leave once both have been accepted.
                awvalid = !aw_done;
                wvalid  = !w_done;
                if ((aw_done || awready) && (w_done || wready)) state_d = WR_RESP;
            end
            WR_RESP: begin
                bready = 1'b1;
                if (bvalid) state_d = RESP;
            end
            RD_REQ: begin
                arvalid = 1'b1;
                if (arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                rready = 1'b1;
                if (rvalid) state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture, per-channel done flags and completion payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q       <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            if (req_valid && req_ready) begin
                req_q   <= '{write: req_write, addr: req_addr, wdata: req_wdata};
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (awvalid && awready) aw_done <= 1'b1;
            if (wvalid && wready)   w_done  <= 1'b1;
            if (bvalid && bready) begin
                rsp_write_q <= 1'b1;
                rsp_rdata_q <= '0;
            end
            if (rvalid && rready) begin
                rsp_write_q <= 1'b0;
                rsp_rdata_q <= rdata;
            end
        end
    end

endmodule

// File: tb/tb_dram_axi_master.sv
// Bench for dram_axi_master: slave model with tunable delays, scoreboard of
// expected completions, AXI stability monitor and directed timing checks.
module tb_dram_axi_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [15:0] req_addr = '0, req_wdata = '0;
    logic        req_ready;
    logic        rsp_valid, rsp_write;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_rdata;
    logic [15:0] awaddr, wdata, araddr, rdata;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;

    always #5 clk = ~clk;

    dram_axi_master #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready)
    );

    // ---------------- checking ----------------
    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        bit          w;
        logic [15:0] d;
    } exp_t;
    exp_t sb[$];

    function automatic logic [15:0] init_val(int i);
        return 16'(i * 40503 + 7);
    endfunction

    bit [15:0] ref_mem [0:255];

    // ---------------- slave model ----------------
    int  aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
    bit  rand_mode = 1'b0, b_early = 1'b0;
    int  aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    int  aw_r, w_r, ar_r, b_r, r_r;
    bit  have_aw, have_w, have_ar, mem_init;
    logic [15:0] aw_a, w_d, ar_a;
    bit [15:0] slv_mem [0:255];
    logic b_pend;

    assign awready = aw_cnt >= (rand_mode ? aw_r : aw_dly);
    assign wready  = w_cnt  >= (rand_mode ? w_r  : w_dly);
    assign arready = ar_cnt >= (rand_mode ? ar_r : ar_dly);
    assign b_pend  = have_w && (have_aw || b_early);
    assign bvalid  = b_pend && (b_cnt >= (rand_mode ? b_r : b_dly));
    assign rvalid  = have_ar && (r_cnt >= (rand_mode ? r_r : r_dly));
    assign rdata   = rvalid ? slv_mem[ar_a[7:0]] : 16'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_r <= 0; w_r <= 0; ar_r <= 0; b_r <= 0; r_r <= 0;
            have_aw <= 0; have_w <= 0; have_ar <= 0;
            aw_a <= '0; w_d <= '0; ar_a <= '0;
            if (!mem_init) begin
                for (int i = 0; i < 256; i++) slv_mem[i] <= init_val(i);
                mem_init <= 1'b1;
            end
        end else begin
            if (awvalid && awready) begin
                have_aw <= 1; aw_a <= awaddr; aw_cnt <= 0; aw_r <= $urandom_range(0, 3);
            end else if (awvalid) aw_cnt <= aw_cnt + 1;
            if (wvalid && wready) begin
                have_w <= 1; w_d <= wdata; w_cnt <= 0; w_r <= $urandom_range(0, 3);
            end else if (wvalid) w_cnt <= w_cnt + 1;
            if (arvalid && arready) begin
                have_ar <= 1; ar_a <= araddr; ar_cnt <= 0; r_cnt <= 0; ar_r <= $urandom_range(0, 3);
            end else if (arvalid) ar_cnt <= ar_cnt + 1;
            if (bvalid && bready) begin
                slv_mem[aw_a[7:0]] <= w_d;
                have_aw <= 0; have_w <= 0; b_cnt <= 0; b_r <= $urandom_range(0, 3);
            end else if (b_pend && !bvalid) b_cnt <= b_cnt + 1;
            if (rvalid && rready) begin
                have_ar <= 0; r_r <= $urandom_range(0, 3);
            end else if (have_ar && !rvalid) r_cnt <= r_cnt + 1;
        end
    end

    // ---------------- AXI stability monitor ----------------
    int viol = 0;
    logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [15:0] p_awa, p_wd, p_ara;

    always @(negedge clk) begin
        if (!rst_n) begin
            p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
        end else begin
            if (p_awv && !p_awr && (!awvalid || awaddr !== p_awa)) viol++;
            if (p_wv && !p_wr && (!wvalid || wdata !== p_wd)) viol++;
            if (p_arv && !p_arr && (!arvalid || araddr !== p_ara)) viol++;
            if (bready && (awvalid || wvalid || rready)) viol++;
            p_awv = awvalid; p_awr = awready; p_awa = awaddr;
            p_wv  = wvalid;  p_wr  = wready;  p_wd  = wdata;
            p_arv = arvalid; p_arr = arready; p_ara = araddr;
        end
    end

    // ---------------- completion consumer ----------------
    int stall_lim = 0;
    bit rsp_rand = 1'b0;
    int rnd_lim = 0;
    int stall_cnt = 0;
    int n_rsp = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            rsp_ready = 0;
            stall_cnt = 0;
        end else if (rsp_valid) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 0);
                rsp_ready = 1;
            end else if (stall_cnt < (rsp_rand ? rnd_lim : stall_lim)) begin
                rsp_ready = 0;
                stall_cnt++;
                chk("stall_rdata", 32'(rsp_rdata), 32'(sb[0].d));
                chk("stall_req_ready", 32'(req_ready), 0);
            end else begin
                rsp_ready = 1;
                chk("rsp_write", 32'(rsp_write), 32'(sb[0].w));
                chk("rsp_rdata", 32'(rsp_rdata), 32'(sb[0].d));
                void'(sb.pop_front());
                stall_cnt = 0;
                n_rsp++;
                rnd_lim = $urandom_range(0, 3);
            end
        end else begin
            rsp_ready = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input bit w, input logic [15:0] a, input logic [15:0] d);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk("req_timeout", 32'(req_ready), 1);
            req_valid = 0;
        end else begin
            e.w = w;
            e.d = w ? 16'h0 : ref_mem[a[7:0]];
            if (w) ref_mem[a[7:0]] = d;
            sb.push_back(e);
            @(posedge clk);
            #1 req_valid = 0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 0);
        @(negedge clk);
    endtask

    task automatic split(input bit aw_slow);
        logic [15:0] a, d;
        int aw_hi, w_hi, b_at;
        a = aw_slow ? 16'h0030 : 16'h0031;
        d = aw_slow ? 16'hA5A5 : 16'h5A5A;
        aw_dly = aw_slow ? 3 : 0;
        w_dly  = aw_slow ? 0 : 3;
        b_early = 1;
        aw_hi = 0; w_hi = 0; b_at = 0;
        send(1, a, d);
        for (int k = 1; k <= 12 && b_at == 0; k++) begin
            if (awvalid) begin aw_hi++; chk("split_awaddr", 32'(awaddr), 32'(a)); end
            if (wvalid)  begin w_hi++;  chk("split_wdata", 32'(wdata), 32'(d)); end
            if (aw_slow && k == 2) begin
                chk("early_bvalid", 32'(bvalid), 1);
                chk("early_bready", 32'(bready), 0);
            end
            if (bready) b_at = k;
            @(posedge clk);
            #1;
        end
        chk("split_aw_cycles", 32'(aw_hi), aw_slow ? 4 : 1);
        chk("split_w_cycles", 32'(w_hi), aw_slow ? 1 : 4);
        chk("split_bready_cycle", 32'(b_at), 5);
        drain();
        aw_dly = 0; w_dly = 0; b_early = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int rv, n0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_valids", 32'({awvalid, wvalid, arvalid, rsp_valid}), 0);
        chk("rst_readies", 32'({bready, rready}), 0);
        chk("rst_addr", 32'({awaddr, araddr}), 0);
        chk("rst_data", 32'({wdata, rsp_rdata}), 0);
        chk("rst_rsp_write", 32'(rsp_write), 0);
        @(posedge clk);
        #2 rst_n = 1;

        // single write, minimum latency
        send(1, 16'h0010, 16'hBEEF);
        chk("wr_c1_awvalid", 32'(awvalid), 1);
        chk("wr_c1_wvalid", 32'(wvalid), 1);
        chk("wr_c1_awaddr", 32'(awaddr), 32'h0010);
        chk("wr_c1_wdata", 32'(wdata), 32'hBEEF);
        chk("wr_c1_bready", 32'(bready), 0);
        @(posedge clk); #1;
        chk("wr_c2_bready", 32'(bready), 1);
        chk("wr_c2_valids", 32'({awvalid, wvalid}), 0);
        @(posedge clk); #1;
        chk("wr_c3_rsp_valid", 32'(rsp_valid), 1);
        chk("wr_c3_rsp_write", 32'(rsp_write), 1);
        chk("wr_c3_rsp_rdata", 32'(rsp_rdata), 0);
        drain();

        // single read, minimum latency (location seeded through the DUT first)
        send(1, 16'h0020, 16'h1234);
        drain();
        send(0, 16'h0020, 16'h0000);
        chk("rd_c1_arvalid", 32'(arvalid), 1);
        chk("rd_c1_araddr", 32'(araddr), 32'h0020);
        chk("rd_c1_rready", 32'(rready), 0);
        @(posedge clk); #1;
        chk("rd_c2_rready", 32'(rready), 1);
        chk("rd_c2_arvalid", 32'(arvalid), 0);
        @(posedge clk); #1;
        chk("rd_c3_rsp_valid", 32'(rsp_valid), 1);
        chk("rd_c3_rsp_write", 32'(rsp_write), 0);
        chk("rd_c3_rsp_rdata", 32'(rsp_rdata), 32'h1234);
        drain();

        // split AW/W handshakes in both orders
        split(1'b1);
        split(1'b0);

        // completion backpressure
        stall_lim = 5;
        send(0, 16'h0010, 16'h0000);
        drain();
        stall_lim = 0;

        // reset in the middle of a read
        ar_dly = 10;
        send(0, 16'h0005, 16'h0000);
        chk("rst_mid_arvalid_pre", 32'(arvalid), 1);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("rst_mid_arvalid", 32'(arvalid), 0);
        chk("rst_mid_rready", 32'(rready), 0);
        chk("rst_mid_req_ready", 32'(req_ready), 1);
        chk("rst_mid_araddr", 32'(araddr), 0);
        sb.delete();
        @(posedge clk);
        #2 rst_n = 1;
        ar_dly = 0;
        rv = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (rsp_valid) rv++;
        end
        chk("rst_mid_no_rsp", 32'(rv), 0);
        chk("rst_mid_req_ready_after", 32'(req_ready), 1);

        // random mixed stream
        rand_mode = 1;
        rsp_rand = 1;
        n0 = n_rsp;
        for (int i = 0; i < 200; i++)
            send(1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom));
        drain();
        chk("rand_count", 32'(n_rsp - n0), 200);
        chk("axi_viol", 32'(viol), 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
